// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding, load-use and branch hazard handling, and a
// mul/div start/done sequencer with a watchdog. Drives the stall/flush controls
// of the pipeline registers and keeps stall/flush performance counters.
//
// Mul/div handshake: MdStart is a one-cycle request raised in the RUN cycle
// where a mul/div instruction is first seen in E. From the next cycle the FSM
// waits in BUSY. In every BUSY cycle MdDone is sampled as a level meaning
// "result valid". The unit must not assert MdDone outside BUSY, because it is
// ignored there. If MdDone never arrives, the watchdog ends the wait after
// MD_TIMEOUT BUSY cycles and sets the sticky MdTimeout flag.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MulDivE,
  input  logic             MdDone,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MdStart,
  output logic             MdTimeout,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount,
  output logic [1:0]       md_state
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam int WD_W = $clog2(MD_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

  md_state_t       state;
  logic [WD_W-1:0] wd_cnt;
  logic            lw_stall;
  logic            md_stall;

  // Forwarding selects: the M stage holds the younger result, so it wins over W
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  // Hazard detection and stall/flush controls; a held E stage is never flushed
  always_comb begin
    lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
    md_stall = ((state == RUN) && MulDivE) || (state == BUSY);
    MdStart  = (state == RUN) && MulDivE;
    StallF   = lw_stall || md_stall;
    StallD   = lw_stall || md_stall;
    StallE   = md_stall;
    FlushM   = md_stall;
    FlushD   = PCSrcE;
    FlushE   = (lw_stall || PCSrcE) && !md_stall;
  end

  assign md_state = state;

  // Mul/div sequencer with watchdog; DONE is a one-cycle gap that blocks restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wd_cnt    <= '0;
      MdTimeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wd_cnt <= '0;
          if (MulDivE) state <= BUSY;
        end
        BUSY: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (MdDone) begin
            state <= DONE;
          end else if (wd_cnt == WD_LAST) begin
            MdTimeout <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          wd_cnt <= '0;
          state  <= RUN;
        end
        default: begin
          wd_cnt <= '0;
          state  <= RUN;
        end
      endcase
    end
  end

  // Performance counters, free-running and wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallF) StallCycles <= StallCycles + CNT_W'(1);
      if (FlushD) FlushCount  <= FlushCount + CNT_W'(1);
    end
  end

endmodule
